hptdc_readout_fifo: RTL and testbench

HPTDC_READOUT_FIFO -- requirements
Module: hptdc_readout_fifo

---
 rtl/hptdc_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/hptdc_readout_fifo.sv | 136 +++++++++++++
 tb/tb_hptdc_readout_fifo.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/hptdc_pkg.sv
// Shared HPTDC word-format constants and a small sizing helper.
package hptdc_pkg;
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int TYPE_MSB = 31;
  localparam int TYPE_LSB = 29;
  localparam logic [2:0] HIT_TYPE = 3'b010;

  // Channel-id width, never narrower than one bit.
  function automatic int ch_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant among requesting channels; combinational grant, pointer
// advances to granted+1 (mod N_CH) whenever a grant is issued.
module rr_arbiter import hptdc_pkg::*; #(
  parameter int N_CH = 4,
  localparam int CW = ch_bits(N_CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] req,
  input  logic            en,
  output logic            gnt_vld,
  output logic [CW-1:0]   gnt_id
);
  logic [CW-1:0] ptr;
  logic [CW:0]   idx;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    idx     = '0;
    for (int k = 0; k < N_CH; k++) begin
      idx = {1'b0, ptr} + (CW+1)'(k);
      if (idx >= (CW+1)'(N_CH)) idx = idx - (CW+1)'(N_CH);
      if (en && !gnt_vld && req[idx[CW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_id  = idx[CW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr <= '0;
    else if (gnt_vld) ptr <= (gnt_id == CW'(N_CH-1)) ? '0 : gnt_id + 1'b1;
  end
endmodule

// File: rtl/hptdc_readout_fifo.sv
// Multi-channel HPTDC readout: edge capture into per-channel hold registers,
// round-robin write into a shared FIFO, show-ahead output with valid/ready.
module hptdc_readout_fifo import hptdc_pkg::*; #(
  parameter int N_CH       = 4,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = 10,
  parameter int FILTER_EN  = 1,
  localparam int CW        = ch_bits(N_CH),
  localparam int LW        = ADDR_WIDTH + 1,
  localparam int DEPTH     = 2**ADDR_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH*DATA_WIDTH-1:0] tdc_data,
  input  logic [N_CH-1:0]          tdc_ready,
  output logic [N_CH-1:0]          tdc_get_data,
  input  logic                     flush,
  output logic [DATA_WIDTH-1:0]    dout,
  output logic [CW-1:0]            dout_ch,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic                     empty,
  output logic                     full,
  output logic [LW-1:0]            level,
  output logic [15:0]              drop_cnt,
  input  logic                     drop_clr
);
  logic [N_CH-1:0]            ready_q, hold_vld, cap, drop;
  logic [DATA_WIDTH-1:0]      hold_dat [N_CH];
  logic [CW+DATA_WIDTH-1:0]   ram [DEPTH];
  logic [ADDR_WIDTH-1:0]      wr_ptr, rd_ptr;
  logic                       gnt_vld, wr_en, wr_d, consume, load, avail;
  logic [CW-1:0]              gnt_id;
  logic [LW-1:0]              level_nxt, shown;
  logic [16:0]                ndrop, dsum;

  always_comb begin
    cap   = '0;
    drop  = '0;
    ndrop = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (tdc_ready[i] && !ready_q[i] && !flush &&
          (FILTER_EN == 0 || tdc_data[i*DATA_WIDTH+TYPE_LSB +: 3] == HIT_TYPE)) begin
        cap[i]  = !hold_vld[i];
        drop[i] = hold_vld[i];
      end
      ndrop = ndrop + 17'(drop[i]);
    end
  end

  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (hold_vld),
    .en      (!full),
    .gnt_vld (gnt_vld),
    .gnt_id  (gnt_id)
  );

  assign wr_en   = gnt_vld && !flush;
  assign consume = dout_valid && dout_ready;
  // dout mirrors the RAM head; a word written last cycle is not yet visible.
  assign shown   = LW'(dout_valid) + LW'(wr_d);
  assign avail   = level > shown;
  assign load    = (!dout_valid || consume) && avail;
  assign level_nxt = level + LW'(wr_en) - LW'(consume);
  assign dsum    = {1'b0, drop_cnt} + ndrop;

  // Edge registers track tdc_ready even in reset so release adds no edge.
  always_ff @(posedge clk) ready_q <= tdc_ready;

  always_ff @(posedge clk) begin
    if (rst) tdc_get_data <= '0;
    else     tdc_get_data <= cap;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      hold_vld <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (cap[i]) hold_vld[i] <= 1'b1;
        else if (wr_en && gnt_id == CW'(i)) hold_vld[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CH; i++)
      if (cap[i]) hold_dat[i] <= tdc_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (wr_en) ram[wr_ptr] <= {gnt_id, hold_dat[gnt_id]};
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      wr_d   <= 1'b0;
      level  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      wr_d  <= wr_en;
      level <= level_nxt;
      empty <= (level_nxt == '0);
      full  <= (level_nxt == LW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      dout_valid <= 1'b0;
      dout       <= '0;
      dout_ch    <= '0;
    end else if (flush) begin
      rd_ptr     <= '0;
      dout_valid <= 1'b0;
    end else if (load) begin
      {dout_ch, dout} <= ram[rd_ptr];
      dout_valid      <= 1'b1;
      rd_ptr          <= rd_ptr + 1'b1;
    end else if (consume) begin
      dout_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || drop_clr)  drop_cnt <= '0;
    else if (dsum > 17'h0FFFF) drop_cnt <= 16'hFFFF;
    else drop_cnt <= dsum[15:0];
  end
endmodule

// File: tb/tb_hptdc_readout_fifo.sv
// Directed self-checking bench for hptdc_readout_fifo (N_CH=4, ADDR_WIDTH=3).
module tb_hptdc_readout_fifo;
  localparam int N_CH = 4;
  localparam int DW   = 32;
  localparam int AW   = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst, flush, dout_ready, drop_clr;
  logic [N_CH*DW-1:0]   tdc_data;
  logic [N_CH-1:0]      tdc_ready, tdc_get_data;
  logic [DW-1:0]        dout;
  logic [1:0]           dout_ch;
  logic                 dout_valid, empty, full;
  logic [AW:0]          level;
  logic [15:0]          drop_cnt;

  int vectors = 0;
  int errors  = 0;
  int gd_cnt  = 0;
  logic [31:0] got_d[$];
  logic [1:0]  got_c[$];

  hptdc_readout_fifo #(.N_CH(N_CH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FILTER_EN(1)) dut (
    .clk(clk), .rst(rst), .tdc_data(tdc_data), .tdc_ready(tdc_ready),
    .tdc_get_data(tdc_get_data), .flush(flush), .dout(dout), .dout_ch(dout_ch),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .empty(empty), .full(full),
    .level(level), .drop_cnt(drop_cnt), .drop_clr(drop_clr)
  );

  // Advance one clock; a word offered now with dout_ready high is consumed at this edge.
  task automatic cyc();
    logic pend;
    logic [31:0] pd;
    logic [1:0] pc;
    pend = dout_valid && dout_ready;
    pd = dout;
    pc = dout_ch;
    @(negedge clk);
    if (pend) begin got_d.push_back(pd); got_c.push_back(pc); end
    gd_cnt += $countones(tdc_get_data);
  endtask

  task automatic hit(input int ch, input logic [31:0] d);
    tdc_data[ch*DW +: DW] = d;
    tdc_ready[ch] = 1'b1;
    cyc();
    tdc_ready[ch] = 1'b0;
    cyc();
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; dout_ready = 1'b0; drop_clr = 1'b0;
    tdc_ready = '0; tdc_data = '0;
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    got_d.delete(); got_c.delete(); gd_cnt = 0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (level !== 4'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
    vectors++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_flags got empty=%b full=%b exp 1/0", empty, full); end
    vectors++; if (dout_valid !== 1'b0 || dout !== 32'h0 || dout_ch !== 2'd0) begin errors++; $display("FAIL reset_dout got v=%b d=%h c=%0d exp 0", dout_valid, dout, dout_ch); end
    vectors++; if (drop_cnt !== 16'd0 || tdc_get_data !== 4'b0) begin errors++; $display("FAIL reset_misc got drop=%0d gd=%b exp 0", drop_cnt, tdc_get_data); end
  endtask

  task automatic test_single_hit();
    do_reset();
    tdc_data[2*DW +: DW] = 32'h4000_0123;
    tdc_ready[2] = 1'b1;
    cyc();
    vectors++; if (tdc_get_data !== 4'b0100) begin errors++; $display("FAIL single_get_data got %b exp 0100", tdc_get_data); end
    cyc();
    vectors++; if (level !== 4'd1 || tdc_get_data !== 4'b0) begin errors++; $display("FAIL single_write got level=%0d gd=%b exp 1/0000", level, tdc_get_data); end
    cyc();
    vectors++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL single_early got valid=%b exp 0", dout_valid); end
    cyc();
    vectors++; if (dout_valid !== 1'b1 || dout !== 32'h4000_0123 || dout_ch !== 2'd2) begin errors++; $display("FAIL single_dout got v=%b d=%h c=%0d exp 1/40000123/2", dout_valid, dout, dout_ch); end
    cyc();
    vectors++; if (dout_valid !== 1'b1 || dout !== 32'h4000_0123 || gd_cnt != 1) begin errors++; $display("FAIL single_hold got v=%b d=%h pulses=%0d exp 1/40000123/1", dout_valid, dout, gd_cnt); end
    dout_ready = 1'b1;
    cyc();
    dout_ready = 1'b0;
    vectors++; if (dout_valid !== 1'b0 || level !== 4'd0 || empty !== 1'b1 || got_d.size() != 1) begin errors++; $display("FAIL single_drain got v=%b level=%0d empty=%b n=%0d exp 0/0/1/1", dout_valid, level, empty, got_d.size()); end
    tdc_ready = '0;
    cyc();
  endtask

  task automatic test_filter();
    gd_cnt = 0;
    tdc_data[0 +: DW] = 32'h2000_0000;
    tdc_ready[0] = 1'b1;
    repeat (5) cyc();
    tdc_ready[0] = 1'b0;
    vectors++; if (gd_cnt != 0) begin errors++; $display("FAIL filter_pulse got %0d exp 0", gd_cnt); end
    vectors++; if (level !== 4'd0 || drop_cnt !== 16'd0 || dout_valid !== 1'b0) begin errors++; $display("FAIL filter_state got level=%0d drop=%0d v=%b exp 0/0/0", level, drop_cnt, dout_valid); end
  endtask

  task automatic test_fairness();
    int first, last;
    do_reset();
    for (int i = 0; i < N_CH; i++) tdc_data[i*DW +: DW] = 32'h4000_00A0 + 32'(i);
    dout_ready = 1'b1;
    tdc_ready = 4'hF;
    first = -1; last = -1;
    for (int c = 0; c < 12; c++) begin
      int n;
      n = got_d.size();
      cyc();
      if (got_d.size() > n) begin if (first < 0) first = c; last = c; end
    end
    tdc_ready = '0;
    dout_ready = 1'b0;
    vectors++; if (got_d.size() != 4) begin errors++; $display("FAIL fair_count got %0d exp 4", got_d.size()); end
    for (int i = 0; i < 4 && i < got_d.size(); i++) begin
      vectors++;
      if (got_c[i] !== 2'(i) || got_d[i] !== 32'h4000_00A0 + 32'(i)) begin errors++; $display("FAIL fair_order[%0d] got ch=%0d d=%h exp ch=%0d d=%h", i, got_c[i], got_d[i], i, 32'h4000_00A0 + 32'(i)); end
    end
    vectors++; if (last - first != 3) begin errors++; $display("FAIL fair_rate got span=%0d exp 3", last - first); end
  endtask

  task automatic fill_full();
    do_reset();
    for (int k = 0; k < 10; k++) begin
      hit(0, 32'h4000_1000 + 32'(k));
      cyc();
    end
    repeat (3) cyc();
  endtask

  task automatic test_full();
    fill_full();
    vectors++; if (level !== 4'd8 || full !== 1'b1) begin errors++; $display("FAIL full_level got level=%0d full=%b exp 8/1", level, full); end
    vectors++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL full_drop got %0d exp 1", drop_cnt); end
    vectors++; if (gd_cnt != 9) begin errors++; $display("FAIL full_pulses got %0d exp 9", gd_cnt); end
    vectors++; if (dout_valid !== 1'b1 || dout !== 32'h4000_1000) begin errors++; $display("FAIL full_head got v=%b d=%h exp 1/40001000", dout_valid, dout); end
    dout_ready = 1'b1;
    repeat (20) cyc();
    dout_ready = 1'b0;
    vectors++; if (got_d.size() != 9) begin errors++; $display("FAIL full_count got %0d exp 9", got_d.size()); end
    for (int k = 0; k < 9 && k < got_d.size(); k++) begin
      vectors++;
      if (got_d[k] !== 32'h4000_1000 + 32'(k) || got_c[k] !== 2'd0) begin errors++; $display("FAIL full_order[%0d] got %h exp %h", k, got_d[k], 32'h4000_1000 + 32'(k)); end
    end
    vectors++; if (empty !== 1'b1 || level !== 4'd0) begin errors++; $display("FAIL full_empty got empty=%b level=%0d exp 1/0", empty, level); end
  endtask

  task automatic test_flush_clr();
    int g;
    fill_full();
    g = gd_cnt;
    tdc_data[3*DW +: DW] = 32'h4000_3333;
    tdc_ready[3] = 1'b1;
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    vectors++; if (level !== 4'd0 || dout_valid !== 1'b0 || empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL flush_state got level=%0d v=%b empty=%b full=%b exp 0/0/1/0", level, dout_valid, empty, full); end
    vectors++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL flush_drop_kept got %0d exp 1", drop_cnt); end
    cyc(); cyc();
    tdc_ready[3] = 1'b0;
    vectors++; if (gd_cnt != g || level !== 4'd0) begin errors++; $display("FAIL flush_edge got pulses=%0d level=%0d exp %0d/0", gd_cnt, level, g); end
    hit(2, 32'h4000_0777);
    repeat (3) cyc();
    vectors++; if (dout_valid !== 1'b1 || dout !== 32'h4000_0777 || dout_ch !== 2'd2) begin errors++; $display("FAIL flush_after got v=%b d=%h c=%0d exp 1/40000777/2", dout_valid, dout, dout_ch); end
    drop_clr = 1'b1;
    cyc();
    drop_clr = 1'b0;
    vectors++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL drop_clr got %0d exp 0", drop_cnt); end
  endtask

  task automatic test_wrap();
    do_reset();
    dout_ready = 1'b1;
    for (int k = 0; k < 20; k++) hit(k % 4, 32'h4000_2000 + 32'(k));
    repeat (6) cyc();
    dout_ready = 1'b0;
    vectors++; if (got_d.size() != 20) begin errors++; $display("FAIL wrap_count got %0d exp 20", got_d.size()); end
    for (int k = 0; k < 20 && k < got_d.size(); k++) begin
      vectors++;
      if (got_d[k] !== 32'h4000_2000 + 32'(k) || got_c[k] !== 2'(k % 4)) begin errors++; $display("FAIL wrap_order[%0d] got ch=%0d d=%h exp ch=%0d d=%h", k, got_c[k], got_d[k], k % 4, 32'h4000_2000 + 32'(k)); end
    end
    vectors++; if (empty !== 1'b1 || dout_valid !== 1'b0) begin errors++; $display("FAIL wrap_empty got empty=%b v=%b exp 1/0", empty, dout_valid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      hit(1, 32'h4000_5000 + 32'(k));
      cyc();
    end
    repeat (2) cyc();
    vectors++; if (level !== 4'd5) begin errors++; $display("FAIL mid_level_before got %0d exp 5", level); end
    rst = 1'b1;
    tdc_ready = 4'hF;
    cyc(); cyc();
    rst = 1'b0;
    gd_cnt = 0;
    repeat (4) cyc();
    vectors++; if (level !== 4'd0 || dout_valid !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL mid_after got level=%0d v=%b empty=%b exp 0/0/1", level, dout_valid, empty); end
    vectors++; if (gd_cnt != 0) begin errors++; $display("FAIL mid_spurious got %0d exp 0", gd_cnt); end
    tdc_ready[1] = 1'b0;
    cyc();
    tdc_ready[1] = 1'b1;
    cyc();
    vectors++; if (tdc_get_data !== 4'b0010) begin errors++; $display("FAIL mid_fresh_edge got %b exp 0010", tdc_get_data); end
    tdc_ready = '0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_filter();
    test_fairness();
    test_full();
    test_flush_clr();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
